// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame geometry
// and the idle bus level.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int   PS2_DATA_BITS = 8;
    localparam logic PS2_LINE_IDLE = 1'b1;

    // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_deserializer_if.sv
// Received-byte stream from the PS/2 deserializer towards the key-code decoder,
// plus status and an FSM debug view.
interface ps2_rx_deserializer_if;
    import ps2_pkg::*;

    // key_changed_out is a one-cycle valid strobe with no ready: the consumer
    // must take key_data_out in the strobe cycle; frame_error never coincides.
    logic [PS2_DATA_BITS-1:0] key_data_out;
    logic                     key_changed_out;
    logic                     frame_error;
    logic                     busy;
    ps2_state_e               state_dbg;

    modport master (
        output key_data_out,
        output key_changed_out,
        output frame_error,
        output busy,
        output state_dbg
    );

    modport slave (
        input key_data_out,
        input key_changed_out,
        input frame_error,
        input busy,
        input state_dbg
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus deglitch counter for one raw PS/2 pin; the output
// follows the pin only after FILTER_LEN consecutive differing samples.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_o
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [7:0] CNT_ONE  = 8'd1;

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= PS2_LINE_IDLE;
            sync2_q <= PS2_LINE_IDLE;
            filt_q  <= PS2_LINE_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample agreeing with the filtered level restarts the run count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host frame receiver: filters the pins, checks start/parity/stop
// and emits each good byte with a one-cycle strobe.
module ps2_rx_deserializer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                         global_clk,
    input  logic                         global_rst_n,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    ps2_rx_deserializer_if.master        key_if
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [2:0]    BIT_LAST = 3'(PS2_DATA_BITS - 1);

    logic clk_filt;
    logic data_filt;
    logic clk_prev_q;
    logic fall;

    ps2_state_e               state_q,       state_d;
    logic [2:0]               bit_cnt_q,     bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q,       shift_d;
    logic                     parity_q,      parity_d;
    logic [TW-1:0]            timeout_q,     timeout_d;
    logic [PS2_DATA_BITS-1:0] key_data_q,    key_data_d;
    logic                     key_changed_q, key_changed_d;
    logic                     frame_error_q, frame_error_d;
    logic                     busy_q,        busy_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i   (global_clk),
        .rst_n_i (global_rst_n),
        .line_i  (ps2_clk),
        .line_o  (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_i   (global_clk),
        .rst_n_i (global_rst_n),
        .line_i  (ps2_data),
        .line_o  (data_filt)
    );

    assign fall = clk_prev_q & ~clk_filt;

    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            clk_prev_q    <= PS2_LINE_IDLE;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            timeout_q     <= '0;
            key_data_q    <= '0;
            key_changed_q <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            clk_prev_q    <= clk_filt;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            timeout_q     <= timeout_d;
            key_data_q    <= key_data_d;
            key_changed_q <= key_changed_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        timeout_d     = '0;
        key_data_d    = key_data_q;
        key_changed_d = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall && !data_filt) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_filt, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_filt;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_filt && odd_parity_ok(shift_q, parity_q)) begin
                        key_data_d    = shift_q;
                        key_changed_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge in the timeout cycle takes priority: the frame keeps going.
        if (state_q != IDLE && !fall) begin
            if (timeout_q == TO_LAST) begin
                state_d       = IDLE;
                frame_error_d = 1'b1;
            end else begin
                timeout_d = timeout_q + TO_ONE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign key_if.key_data_out    = key_data_q;
    assign key_if.key_changed_out = key_changed_q;
    assign key_if.frame_error     = frame_error_q;
    assign key_if.busy            = busy_q;
    assign key_if.state_dbg       = state_q;

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Directed bench for ps2_rx_deserializer: drives PS/2 frames on the raw pins and
// checks received bytes, error strobes, timeout timing and reset behaviour.
module tb_ps2_rx_deserializer;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 10000;
    localparam int HALF           = 40;

    logic global_clk   = 1'b0;
    logic global_rst_n = 1'b0;
    logic ps2_clk      = 1'b1;
    logic ps2_data     = 1'b1;

    ps2_rx_deserializer_if key_if ();

    ps2_rx_deserializer #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .global_clk   (global_clk),
        .global_rst_n (global_rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_if       (key_if.master)
    );

    always #10 global_clk = ~global_clk;

    int         cyc           = 0;
    int         changed_cnt   = 0;
    int         err_cnt       = 0;
    int         both_cnt      = 0;
    int         long_cnt      = 0;
    int         last_err_cyc  = 0;
    int         last_fall_cyc = 0;
    int         checks        = 0;
    int         fails         = 0;
    logic       prev_changed  = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(posedge global_clk) cyc <= cyc + 1;

    always @(negedge global_clk) begin
        if (key_if.key_changed_out === 1'b1) begin
            changed_cnt++;
            got_q.push_back(key_if.key_data_out);
        end
        if (key_if.frame_error === 1'b1) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (key_if.key_changed_out === 1'b1 && key_if.frame_error === 1'b1) both_cnt++;
        if (key_if.key_changed_out === 1'b1 && prev_changed) long_cnt++;
        prev_changed = (key_if.key_changed_out === 1'b1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge global_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] g;
        logic [7:0] e;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_byte"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            wait_cycles(5);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2 - 8);
        end else begin
            wait_cycles(HALF / 2);
        end
        ps2_clk       = 1'b0;
        last_fall_cyc = cyc;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
        wait_cycles(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_bit);
        ps2_data = 1'b1;
    endtask

    initial begin
        int base_changed;
        int base_err;
        logic [7:0] c3;

        wait_cycles(5);
        check("rst_key_data", 32'(key_if.key_data_out), 32'h00);
        check("rst_changed", 32'(key_if.key_changed_out), 32'h0);
        check("rst_frame_error", 32'(key_if.frame_error), 32'h0);
        check("rst_busy", 32'(key_if.busy), 32'h0);
        check("rst_state", 32'(key_if.state_dbg), 32'(IDLE));
        global_rst_n = 1'b1;
        wait_cycles(20);

        // Single good frame.
        send_frame(8'h1C, 1'b0, -1);
        exp_q.push_back(8'h1C);
        wait_cycles(20);
        check_bytes("good_1c");
        check("good_1c_data_out", 32'(key_if.key_data_out), 32'h1C);
        check("good_1c_no_err", 32'(err_cnt), 32'd0);
        check("good_1c_busy", 32'(key_if.busy), 32'h0);

        // Back-to-back break sequence.
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h74, 1'b0, -1);
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h74);
        wait_cycles(20);
        check_bytes("seq");
        check("seq_no_err", 32'(err_cnt), 32'd0);

        // Wrong parity: error strobe, data held.
        base_changed = changed_cnt;
        send_frame(8'h1C, 1'b1, -1);
        wait_cycles(20);
        check("parity_err_cnt", 32'(err_cnt), 32'd1);
        check("parity_no_changed", 32'(changed_cnt), 32'(base_changed));
        check("parity_data_kept", 32'(key_if.key_data_out), 32'h74);

        // Timeout after start + 3 data bits. Pin fall reaches the FSM after
        // 2 sync + FILTER_LEN + 1 edge-register cycles; the error registers
        // on the TIMEOUT_CYCLES-th edgeless cycle after that.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("timeout_busy_mid", 32'(key_if.busy), 32'h1);
        wait_cycles(12000);
        check("timeout_err_cnt", 32'(err_cnt), 32'd2);
        check("timeout_delay", 32'(last_err_cyc - last_fall_cyc),
              32'(TIMEOUT_CYCLES + FILTER_LEN + 3));
        check("timeout_busy", 32'(key_if.busy), 32'h0);
        send_frame(8'h29, 1'b0, -1);
        exp_q.push_back(8'h29);
        wait_cycles(20);
        check_bytes("after_timeout");

        // Short glitches on the clock pin.
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(20);
        check("glitch_idle_busy", 32'(key_if.busy), 32'h0);
        check("glitch_idle_state", 32'(key_if.state_dbg), 32'(IDLE));
        send_frame(8'hA5, 1'b0, 4);
        exp_q.push_back(8'hA5);
        wait_cycles(20);
        check_bytes("glitch_mid");
        check("glitch_no_err", 32'(err_cnt), 32'd2);

        // Reset after data bit 5 of 8'hC3; the remaining bits are all ones.
        c3 = 8'hC3;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(c3[i], 1'b0);
        check("pre_rst_busy", 32'(key_if.busy), 32'h1);
        global_rst_n = 1'b0;
        #1;
        check("midrst_key_data", 32'(key_if.key_data_out), 32'h00);
        check("midrst_busy", 32'(key_if.busy), 32'h0);
        check("midrst_changed", 32'(key_if.key_changed_out), 32'h0);
        check("midrst_frame_error", 32'(key_if.frame_error), 32'h0);
        wait_cycles(4);
        global_rst_n = 1'b1;
        base_changed = changed_cnt;
        base_err     = err_cnt;
        send_bit(c3[6], 1'b0);
        send_bit(c3[7], 1'b0);
        send_bit(~^c3, 1'b0);
        send_bit(1'b1, 1'b0);
        wait_cycles(20);
        check("remainder_no_changed", 32'(changed_cnt), 32'(base_changed));
        check("remainder_no_err", 32'(err_cnt), 32'(base_err));
        check("remainder_busy", 32'(key_if.busy), 32'h0);
        send_frame(8'h5A, 1'b0, -1);
        exp_q.push_back(8'h5A);
        wait_cycles(20);
        check_bytes("after_reset");
        check("after_reset_data_out", 32'(key_if.key_data_out), 32'h5A);

        check("strobes_overlap", 32'(both_cnt), 32'd0);
        check("strobe_width", 32'(long_cnt), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
